// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, in-order imem request tracking, and the
// registered instruction FIFO that feeds the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp,
  input  logic [31:0] jmp_addr,
  input  logic        if_id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_addr_to_if_id,
  output logic [31:0] inst_to_if_id,
  output logic        inst_valid
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   jmp_target;

  // In-flight tracker; killed entries are always the oldest, so a count suffices
  logic [31:0]   trk_addr [DEPTH];
  logic [AW-1:0] trk_wr;
  logic [AW-1:0] trk_rd;
  logic [CW-1:0] inflight;
  logic [CW-1:0] kill_cnt;

  logic [31:0]   out_addr [DEPTH];
  logic [31:0]   out_inst [DEPTH];
  logic [AW-1:0] out_wr;
  logic [AW-1:0] out_rd;
  logic [CW-1:0] out_count;

  logic [CW:0]   occupancy;
  logic          accept;
  logic          resp;
  logic          push;
  logic          pop;

  assign jmp_target = jmp_addr & ~32'h0000_0003;
  assign occupancy  = {1'b0, inflight} + {1'b0, out_count};

  assign imem_req   = !rst && !jmp && (occupancy < LIMIT);
  assign imem_addr  = fetch_pc;

  assign accept     = imem_req && imem_gnt;
  assign resp       = imem_rvalid && (inflight != '0);
  assign push       = resp && (kill_cnt == '0) && !jmp;
  assign inst_valid = (out_count != '0);
  assign pop        = inst_valid && !if_id_stall && !jmp;

  assign inst_addr_to_if_id = inst_valid ? out_addr[out_rd] : 32'h0000_0000;
  assign inst_to_if_id      = inst_valid ? out_inst[out_rd] : NOP;

  // Control state: PC, pointers and occupancy counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      trk_wr    <= '0;
      trk_rd    <= '0;
      inflight  <= '0;
      kill_cnt  <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else begin
      if (jmp) begin
        fetch_pc <= jmp_target;
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (accept) trk_wr <= trk_wr + AW'(1);
      if (resp)   trk_rd <= trk_rd + AW'(1);
      inflight <= inflight + CW'(accept) - CW'(resp);

      // Everything still outstanding after a redirect is stale
      if (jmp) begin
        kill_cnt <= inflight - CW'(resp);
      end else if (resp && (kill_cnt != '0)) begin
        kill_cnt <= kill_cnt - CW'(1);
      end

      if (jmp) begin
        out_wr    <= '0;
        out_rd    <= '0;
        out_count <= '0;
      end else begin
        if (push) out_wr <= out_wr + AW'(1);
        if (pop)  out_rd <= out_rd + AW'(1);
        out_count <= out_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; validity lives in the counters
  always_ff @(posedge clk) begin
    if (accept) trk_addr[trk_wr] <= fetch_pc;
    if (push) begin
      out_addr[out_wr] <= trk_addr[trk_rd];
      out_inst[out_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, stall backpressure, redirects,
// PC wraparound, spurious responses and mid-stream reset.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic        if_id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_addr_to_if_id;
  logic [31:0] inst_to_if_id;
  logic        inst_valid;

  if_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .jmp(jmp), .jmp_addr(jmp_addr),
    .if_id_stall(if_id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_addr_to_if_id(inst_addr_to_if_id), .inst_to_if_id(inst_to_if_id),
    .inst_valid(inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t q[$];
  int   cyc;
  int   k;
  bit   spur;
  bit   from_q;
  int   n_assert;
  int   n_fail;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_pres(input string tag, input logic [31:0] a);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_addr"}, inst_addr_to_if_id, a);
    chk({tag, "_inst"}, inst_to_if_id, f(a));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_addr"}, inst_addr_to_if_id, 32'h0);
    chk({tag, "_inst"}, inst_to_if_id, 32'h0000_0013);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] a);
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_iaddr"}, imem_addr, a);
  endtask

  task automatic chk_noreq(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
  endtask

  // Memory model: in-order responses, each no earlier than k cycles after accept
  task automatic drive_mem();
    from_q = 1'b0;
    if (q.size() != 0 && q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = f(q[0].addr);
      from_q      = 1'b1;
    end else if (spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic step(input logic j, input logic [31:0] ja, input logic st);
    jmp         = j;
    jmp_addr    = ja;
    if_id_stall = st;
    drive_mem();
    #1;
  endtask

  task automatic end_cycle();
    req_t r;
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + k;
      q.push_back(r);
    end
    @(posedge clk);
    if (from_q) void'(q.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    cyc         = 0;
    k           = 1;
    spur        = 1'b0;
    from_q      = 1'b0;
    rst         = 1'b1;
    jmp         = 1'b0;
    jmp_addr    = 32'h0;
    if_id_stall = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk_empty("in_reset");
    chk_noreq("in_reset");
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;

    // Streaming from RESET_PC, k=1
    step(0, 0, 0); chk_empty("c1"); chk_req("c1", 32'h100); end_cycle();
    step(0, 0, 0); chk_empty("c2"); chk_req("c2", 32'h104); end_cycle();
    step(0, 0, 0); chk_pres("c3", 32'h100); end_cycle();

    // Stall 8 cycles while 0x104 is presented
    step(0, 0, 1); chk_pres("c4", 32'h104); end_cycle();
    for (int i = 5; i <= 11; i++) begin
      step(0, 0, 1);
      chk_pres($sformatf("stall_c%0d", i), 32'h104);
      if (i >= 6) chk_noreq($sformatf("stall_c%0d", i));
      end_cycle();
    end
    k = 3;
    step(0, 0, 0); chk_pres("c12", 32'h104); chk_noreq("c12"); end_cycle();
    step(0, 0, 0); chk_pres("c13", 32'h108); chk_req("c13", 32'h114); end_cycle();
    step(0, 0, 0); chk_pres("c14", 32'h10C); end_cycle();

    // Redirect with two fetches in flight; target low bits ignored
    step(1, 32'h2003, 0); chk_pres("c15", 32'h110); chk_noreq("c15"); end_cycle();
    step(0, 0, 0); chk_empty("c16"); chk_req("c16", 32'h2000); end_cycle();
    step(0, 0, 0); chk_empty("c17"); chk_req("c17", 32'h2004); end_cycle();
    step(0, 0, 0); chk_empty("c18"); end_cycle();
    step(0, 0, 0); chk_empty("c19"); end_cycle();

    // Redirect colliding with a response and a stall
    step(1, 32'h3000, 1); chk_pres("c20", 32'h2000); chk_noreq("c20"); end_cycle();
    step(0, 0, 0); chk_empty("c21"); chk_req("c21", 32'h3000); end_cycle();
    step(0, 0, 0); chk_empty("c22"); chk_req("c22", 32'h3004); end_cycle();

    // Second redirect before the first target returns
    step(1, 32'h4000, 0); chk_empty("c23"); chk_noreq("c23"); end_cycle();
    step(0, 0, 0); chk_empty("c24"); chk_req("c24", 32'h4000); end_cycle();
    step(0, 0, 0); chk_empty("c25"); end_cycle();
    step(0, 0, 0); chk_empty("c26"); end_cycle();
    step(0, 0, 0); chk_empty("c27"); end_cycle();

    // Wraparound at the top of the address space
    k = 1;
    step(1, 32'hFFFF_FFF8, 0); chk_pres("c28", 32'h4000); end_cycle();
    step(0, 0, 0); chk_empty("c29"); chk_req("c29", 32'hFFFF_FFF8); end_cycle();
    step(0, 0, 0); chk_empty("c30"); chk_req("c30", 32'hFFFF_FFFC); end_cycle();
    step(0, 0, 0); chk_empty("c31"); chk_req("c31", 32'h0000_0000); end_cycle();
    step(0, 0, 0); chk_pres("c32", 32'hFFFF_FFF8); end_cycle();
    step(0, 0, 0); chk_pres("c33", 32'hFFFF_FFFC); end_cycle();
    step(0, 0, 0); chk_pres("c34", 32'h0000_0000); end_cycle();

    // Drain the tracker under stall, then a spurious response
    step(0, 0, 1); chk_pres("c35", 32'h4); end_cycle();
    step(0, 0, 1); chk_pres("c36", 32'h4); chk_noreq("c36"); end_cycle();
    step(0, 0, 1); chk_pres("c37", 32'h4); chk_noreq("c37"); end_cycle();
    spur = 1'b1;
    step(0, 0, 1); chk_pres("c38", 32'h4); chk_noreq("c38");
    spur = 1'b0;
    end_cycle();
    step(0, 0, 0); chk_pres("c39", 32'h4); end_cycle();
    step(0, 0, 0); chk_pres("c40", 32'h8); end_cycle();
    step(0, 0, 0); chk_pres("c41", 32'hC); end_cycle();
    step(0, 0, 0); chk_pres("c42", 32'h10); end_cycle();

    // Reset with three buffered entries
    step(0, 0, 1); chk_pres("c43", 32'h14); end_cycle();
    step(0, 0, 1); chk_pres("c44", 32'h14);
    rst = 1'b1;
    #1;
    chk_empty("rst_mid"); chk_noreq("rst_mid");
    end_cycle();
    step(0, 0, 0); chk_empty("c45"); chk_noreq("c45"); end_cycle();
    rst  = 1'b0;
    spur = 1'b1;
    step(0, 0, 0); chk_empty("c46"); chk_req("c46", 32'h100);
    spur = 1'b0;
    end_cycle();
    step(0, 0, 0); chk_empty("c47"); chk_req("c47", 32'h104); end_cycle();
    step(0, 0, 0); chk_pres("c48", 32'h100); end_cycle();
    step(0, 0, 0); chk_pres("c49", 32'h104); end_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipeline and producer side of the IF/ID register. Holds the PC, issues in-order requests to instruction memory over a request/grant/response handshake, and buffers returned instructions with their addresses. Presents one instruction per cycle to IF/ID, holds it under `if_id_stall`, and discards in-flight fetches on a `jmp` redirect.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, 4: power of two, at least 2. Sets the output FIFO depth and the in-flight tracker depth.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `jmp` in 1: redirect request.
- `jmp_addr` in 32: redirect target. Bits [1:0] are forced to 0.
- `if_id_stall` in 1: IF/ID is not taking the presented instruction.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_gnt` in 1: a request is accepted when `imem_req` and `imem_gnt` are both 1.
- `imem_rvalid` in 1: response valid. Responses return in order, at least 1 cycle after acceptance.
- `imem_rdata` in 32: response instruction.
- `inst_addr_to_if_id` out 32: address of the presented instruction.
- `inst_to_if_id` out 32: presented instruction.
- `inst_valid` out 1: presented instruction is valid.

## Operation
- **State:**
  - `fetch_pc`.
  - In-flight tracker: FIFO of {addr, kill}, `DEPTH` entries.
  - Output FIFO: {addr, inst}, `DEPTH` entries, count 0..`DEPTH`.
- **Issue:**
  - `imem_req = !jmp && (inflight + out_count) < DEPTH`, where `inflight` includes killed entries.
  - `imem_addr = fetch_pc`.
- **On accept:**
  - Push {`fetch_pc`, kill=0} into the tracker.
  - `fetch_pc <= fetch_pc + 4`, wrapping mod 2^32. 32'hFFFF_FFFC is followed by 32'h0.
- **On `imem_rvalid`:**
  - Pop the tracker head.
  - If kill=0, push {head addr, `imem_rdata`} into the output FIFO.
  - If kill=1, drop the response.
  - `imem_rvalid` with an empty tracker is ignored. No state changes.
- **Presentation:**
  - `inst_valid = out_count != 0`.
  - When valid, outputs show the FIFO head.
  - When empty, outputs show addr 32'h0 and inst 32'h0000_0013 (NOP).
- **Pop:** `inst_valid && !if_id_stall && !jmp`.
- **Redirect (`jmp`=1):**
  - `jmp` has priority over `if_id_stall`, pop, and issue.
  - `fetch_pc <= {jmp_addr[31:2], 2'b00}`.
  - Output FIFO is cleared.
  - Every tracker entry present at the end of the cycle gets kill=1. This includes an entry popped by a same-cycle `imem_rvalid`, whose data is dropped.
  - `imem_req` is 0 during the `jmp` cycle.
- **Simultaneous push and pop:** allowed in the same cycle; `out_count` is unchanged. The same applies to a simultaneous tracker push and pop.
- **Overflow:** the issue rule prevents output FIFO overflow; no full-drop path exists.

## Timing
- **Reset values (async, active while `rst`=1):**
  - `fetch_pc` = `RESET_PC`.
  - Tracker and output FIFO are empty.
  - `imem_req` = 0.
  - `inst_valid` = 0, `inst_addr_to_if_id` = 0, `inst_to_if_id` = 32'h0000_0013.
- **After reset release:** `imem_req` = 1 in the first cycle after release, with `imem_addr` = `RESET_PC`.
- **Latency:** accept in cycle N, `imem_rvalid` in N+k. The instruction is presented (`inst_valid`=1) in N+k+1, because the FIFO is registered.
- **Throughput:** with k=1, constant grant and no stall, the block sustains 1 instruction per cycle at `DEPTH`=4 with no bubbles.
- **Redirect:** `jmp` in cycle J gives `inst_valid`=0 in J+1, and `imem_req` with `imem_addr` = target in J+1, provided the issue rule allows.
- **Stall:**
  - While `if_id_stall`=1, presented outputs hold bit-stable.
  - Fetches continue until `inflight + out_count` = `DEPTH`, then `imem_req` drops.
- **Reset mid-operation:** `rst` clears all state. Responses arriving after release with an empty tracker are ignored.

## Test plan
- **Reset and streaming:** `RESET_PC`=32'h100, k=1, grant always, no stall. Expect `inst_valid` from cycle 3, then addresses 0x100, 0x104, 0x108… on consecutive cycles with matching data.
- **Stall with backpressure:**
  - Hold `if_id_stall`=1 for 8 cycles. Expect outputs frozen at 0x104 and `imem_req`=0 once 4 entries are buffered or in flight.
  - Release the stall. Expect 0x108–0x110 with no gaps or duplicates.
- **Redirect with 2 in flight:** k=3, `jmp_addr`=32'h2003. Expect both old responses dropped, next request at 0x2000, and first valid output addr 0x2000.
- **Redirect collisions:**
  - `jmp` together with `imem_rvalid` and `if_id_stall`=1: expect that response dropped, FIFO empty next cycle, target fetched.
  - Then a second `jmp` before the target returns: only the second target is presented.
- **Wraparound and spurious response:**
  - `jmp_addr`=32'hFFFF_FFF8: expect outputs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
  - `imem_rvalid` pulsed with nothing in flight: no output change.
- **Reset mid-stream:** `rst` pulsed with 3 buffered entries. Expect immediate `inst_valid`=0 and NOP on `inst_to_if_id`, with fetching restarting at `RESET_PC`.
